hazard_forward_ctrl: RTL

- Parametrised hazard and forwarding controller for the pipelined RISC-V core; supersedes the separate hazard and data-forwarding logic.
- Keeps its own shadow pipeline of destination-register info for the EX stage and FWD_DEPTH later stages.
- Decides load-use stalls for any load latency, issues branch flush and bubble controls, and produces registered forwarding selects for both ALU operands.
- Sits beside IF_ID/ID_EX; its outputs drive PC write, IF/ID write, IF/ID flush, ID/EX bubble, and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_forward_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
package hazard_pkg;

   // Widest register address the shadow entries can hold; narrower
   // cores zero-extend their register numbers into this field.
   localparam int REG_AW_MAX = 8;

   // Forward select encodings for the classic five-stage pipeline.
   localparam int FWD_RF    = 0;
   localparam int FWD_EXMEM = 1;
   localparam int FWD_MEMWB = 2;

   // One shadow pipeline entry describing an in-flight producer.
   typedef struct packed {
      logic                  v;
      logic [REG_AW_MAX-1:0] rd;
      logic                  wr;
      logic                  ld;
   } shadow_entry_t;

   // Width of a forward select able to name stages 0..depth.
   function automatic int fw_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one shadow pipeline entry.
module hazard_match
   import hazard_pkg::*;
(
   input  shadow_entry_t         entry,
   input  logic [REG_AW_MAX-1:0] rs,
   input  logic                  use_rs,
   output logic                  match,
   output logic                  ld_match
);

   // x0 is hard-wired to zero, so a write to it is never a real producer.
   assign match    = use_rs & entry.v & entry.wr & (entry.rd != '0) & (entry.rd == rs);
   assign ld_match = match & entry.ld;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and operand forwarding control for the
// pipelined core. A private shadow pipeline tracks the destination of
// every instruction from EX onward so hazards are seen from ID.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_LAT  = 1,
   parameter int CNT_W     = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             id_valid,
   input  logic [REG_AW-1:0]                id_rs1,
   input  logic [REG_AW-1:0]                id_rs2,
   input  logic                             id_use_rs1,
   input  logic                             id_use_rs2,
   input  logic [REG_AW-1:0]                id_rd,
   input  logic                             id_regwrite,
   input  logic                             id_memread,
   input  logic                             ex_branch_taken,
   output logic                             pc_write,
   output logic                             ifid_write,
   output logic                             ifid_flush,
   output logic                             idex_bubble,
   output logic [fw_width(FWD_DEPTH)-1:0]   fwd_a,
   output logic [fw_width(FWD_DEPTH)-1:0]   fwd_b,
   output logic [CNT_W-1:0]                 stall_cnt,
   output logic [CNT_W-1:0]                 flush_cnt
);

   localparam int FW = fw_width(FWD_DEPTH);

   // Stage 0 is EX, stage s is s stages after EX.
   shadow_entry_t sh [FWD_DEPTH+1];
   shadow_entry_t sh_in;

   logic [REG_AW_MAX-1:0] rs1_x;
   logic [REG_AW_MAX-1:0] rs2_x;

   logic m_a [FWD_DEPTH+1];
   logic l_a [FWD_DEPTH+1];
   logic m_b [FWD_DEPTH+1];
   logic l_b [FWD_DEPTH+1];

   logic          load_hazard;
   logic [FW-1:0] fwd_a_nxt;
   logic [FW-1:0] fwd_b_nxt;

   assign rs1_x = REG_AW_MAX'(id_rs1);
   assign rs2_x = REG_AW_MAX'(id_rs2);

   // One comparator pair per shadow stage, one for each source operand.
   for (genvar s = 0; s <= FWD_DEPTH; s++) begin : g_stage
      hazard_match u_match_a (
         .entry    (sh[s]),
         .rs       (rs1_x),
         .use_rs   (id_use_rs1),
         .match    (m_a[s]),
         .ld_match (l_a[s])
      );
      hazard_match u_match_b (
         .entry    (sh[s]),
         .rs       (rs2_x),
         .use_rs   (id_use_rs2),
         .match    (m_b[s]),
         .ld_match (l_b[s])
      );
   end

   // Stall while a matching load has not yet reached the stage where its data exists.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      load_hazard = 1'b0;
      for (int s = 0; s < LOAD_LAT; s++) begin
         if (l_a[s] | l_b[s]) load_hazard = 1'b1;
      end
      load_hazard = load_hazard & id_valid & ~ex_branch_taken;
   end

   // Pick the youngest matching producer; scanning oldest-first lets the youngest overwrite.
   always_comb begin
      fwd_a_nxt = FW'(FWD_RF);
      fwd_b_nxt = FW'(FWD_RF);
      for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
         if (m_a[s]) fwd_a_nxt = FW'(s + 1);
         if (m_b[s]) fwd_b_nxt = FW'(s + 1);
      end
   end

   // Pipeline controls; a taken branch outranks a load-use stall, and reset forces the idle pattern.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rst_n) begin
         if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   // Entry entering EX next cycle; a bubble enters as invalid.
   always_comb begin
      sh_in    = '0;
      sh_in.v  = id_valid & ~idex_bubble;
      sh_in.rd = REG_AW_MAX'(id_rd);
      sh_in.wr = id_regwrite;
      sh_in.ld = id_memread;
   end

   // Shadow pipeline shift; reset clears every stage so no pre-reset producer is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= FWD_DEPTH; s++) sh[s] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the pre-edge value, so the shift order does not matter.
         sh[0] <= sh_in;
         for (int s = 1; s <= FWD_DEPTH; s++) sh[s] <= sh[s-1];
      end
   end

   // Forward selects follow the instruction into EX; a bubble reads the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a <= FW'(FWD_RF);
         fwd_b <= FW'(FWD_RF);
      end else if (idex_bubble) begin
         fwd_a <= FW'(FWD_RF);
         fwd_b <= FW'(FWD_RF);
      end else begin
         fwd_a <= fwd_a_nxt;
         fwd_b <= fwd_b_nxt;
      end
   end

   // Saturating performance counters for stall and flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (load_hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ex_branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
